post_process: RTL

- Parametrised post-accumulation stage for the convolution layer datapath, placed between the MAC/adder tree and the image write-back.
- Handles DEPTH_NB channels in parallel. Per channel: bias add, then max-pool or sum-pool over a configurable window, then optional ReLU, then rounded arithmetic shift with saturation to image width.
- Output goes through a credit-guarded FIFO with a valid/ready handshake.
- Generalises the existing fixed single-channel pool/relu/rescale path with runtime pool mode, rounding, saturation and partial-window flush.

---
 rtl/post_process_pkg.sv | 20 ++
 rtl/post_process_fifo.sv | 43 ++++
 rtl/post_process.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/post_process_pkg.sv
// Shared constants for the post-accumulation stage: config address, config field layout
// and the pooling FSM state type.
package post_process_pkg;

  localparam int unsigned CFG_LAYERS = 4;

  localparam int unsigned SHIFT_LSB = 0;
  localparam int unsigned SHIFT_W   = 8;
  localparam int unsigned POOL_LSB  = 8;
  localparam int unsigned POOL_W    = 8;
  localparam int unsigned RELU_BIT  = 16;
  localparam int unsigned AVG_BIT   = 17;
  localparam int unsigned ROUND_BIT = 18;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } pool_state_e;

endpackage

// File: rtl/post_process_fifo.sv
// First-word fall-through FIFO with occupancy count. Push while full is accepted only
// when a pop happens in the same cycle; pop while empty is ignored.
module post_process_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             full, pop_ok, push_ok;

  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (count_o == '0);
  assign full    = (count_o == (AW + 1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full || pop_ok);
  assign rdata_o = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/post_process.sv
// Per-channel bias add, max/sum pooling, ReLU and rounded saturating rescale, feeding a
// credit-guarded output FIFO. Beat -> stage1 reg -> pool reg -> rescale into FIFO.
module post_process
  import post_process_pkg::*;
#(
  parameter int unsigned DEPTH_NB   = 4,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned IMG_WIDTH  = 16,
  parameter int unsigned CFG_DWIDTH = 32,
  parameter int unsigned CFG_AWIDTH = 5,
  parameter int unsigned POOL_MAX   = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CFG_DWIDTH-1:0]         cfg_data,
  input  logic [CFG_AWIDTH-1:0]         cfg_addr,
  input  logic                          cfg_valid,
  input  logic [DEPTH_NB*ACC_WIDTH-1:0] bias_bus,
  input  logic [DEPTH_NB*ACC_WIDTH-1:0] acc_bus,
  input  logic                          acc_val,
  input  logic                          acc_last,
  output logic                          acc_rdy,
  output logic [DEPTH_NB*IMG_WIDTH-1:0] result_bus,
  output logic                          result_last,
  output logic                          result_val,
  input  logic                          result_rdy
);

  localparam int unsigned CntW     = $clog2(POOL_MAX + 1);
  localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OccW     = FifoCntW + 1;
  localparam int unsigned ResW     = DEPTH_NB * IMG_WIDTH;

  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(input logic [ACC_WIDTH:0] v);
    if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) return {v[ACC_WIDTH], {(ACC_WIDTH-1){~v[ACC_WIDTH]}}};
    return v[ACC_WIDTH-1:0];
  endfunction

  logic [7:0]      sh_shift_q, sh_pool_q, shift_q;
  logic            sh_relu_q, sh_avg_q, sh_round_q, cfg_pend_q;
  logic [CntW-1:0] pool_nb_q, pool_clamped;
  logic            relu_q, avg_q, round_q;
  logic            cfg_wr, cfg_copy, accept;
  logic            unused_cfg;

  pool_state_e     st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load, emit;
  logic [OccW-1:0] in_flight_q, in_flight_d, fifo_next;
  logic            acc_rdy_q, acc_rdy_d;
  logic            s1_val_q, s1_load_q, s1_emit_q, s1_last_q, s2_emit_q, s2_last_q;

  logic [ResW-1:0]     res_bus;
  logic [ResW:0]       fifo_rdata;
  logic                fifo_empty, pop_ok;
  logic [FifoCntW-1:0] fifo_count;

  assign unused_cfg = ^cfg_data[CFG_DWIDTH-1:ROUND_BIT+1];
  assign cfg_wr     = cfg_valid && (cfg_addr == CFG_AWIDTH'(CFG_LAYERS));
  assign accept     = acc_val && acc_rdy_q;
  // Active config only changes when no window or result is anywhere in the pipeline.
  assign cfg_copy   = cfg_pend_q && (st_q == StIdle) && (in_flight_q == '0) && !accept;
  assign acc_rdy    = acc_rdy_q;

  always_comb begin
    if (sh_pool_q == 8'd0)                pool_clamped = CntW'(1);
    else if (sh_pool_q > 8'(POOL_MAX))    pool_clamped = CntW'(POOL_MAX);
    else                                  pool_clamped = sh_pool_q[CntW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_shift_q <= '0;
      sh_pool_q  <= 8'd1;
      sh_relu_q  <= 1'b0;
      sh_avg_q   <= 1'b0;
      sh_round_q <= 1'b0;
      cfg_pend_q <= 1'b0;
      shift_q    <= '0;
      pool_nb_q  <= CntW'(1);
      relu_q     <= 1'b0;
      avg_q      <= 1'b0;
      round_q    <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_shift_q <= cfg_data[SHIFT_LSB +: SHIFT_W];
        sh_pool_q  <= cfg_data[POOL_LSB +: POOL_W];
        sh_relu_q  <= cfg_data[RELU_BIT];
        sh_avg_q   <= cfg_data[AVG_BIT];
        sh_round_q <= cfg_data[ROUND_BIT];
        cfg_pend_q <= 1'b1;
      end else if (cfg_copy) begin
        cfg_pend_q <= 1'b0;
      end
      if (cfg_copy) begin
        shift_q   <= sh_shift_q;
        pool_nb_q <= pool_clamped;
        relu_q    <= sh_relu_q;
        avg_q     <= sh_avg_q;
        round_q   <= sh_round_q;
      end
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    load  = 1'b0;
    emit  = 1'b0;
    if (accept) begin
      case (st_q)
        StIdle: begin
          load = 1'b1;
          if (pool_nb_q == CntW'(1) || acc_last) begin
            emit = 1'b1;
          end else begin
            cnt_d = CntW'(1);
            st_d  = StAccum;
          end
        end
        StAccum: begin
          if (cnt_q == pool_nb_q - CntW'(1) || acc_last) begin
            emit  = 1'b1;
            cnt_d = '0;
            st_d  = StIdle;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: st_d = StIdle;
      endcase
    end
  end

  // Credits: a window holds a FIFO slot from its first beat until it is pushed.
  always_comb begin
    in_flight_d = in_flight_q;
    if (accept && st_q == StIdle) in_flight_d = in_flight_d + OccW'(1);
    if (s2_emit_q)                in_flight_d = in_flight_d - OccW'(1);
    fifo_next = OccW'(fifo_count) + OccW'(s2_emit_q) - OccW'(pop_ok);
    acc_rdy_d = (fifo_next + in_flight_d) < OccW'(FIFO_DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q        <= StIdle;
      cnt_q       <= '0;
      in_flight_q <= '0;
      acc_rdy_q   <= 1'b0;
      s1_val_q    <= 1'b0;
      s1_load_q   <= 1'b0;
      s1_emit_q   <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_emit_q   <= 1'b0;
      s2_last_q   <= 1'b0;
    end else begin
      st_q        <= st_d;
      cnt_q       <= cnt_d;
      in_flight_q <= in_flight_d;
      acc_rdy_q   <= acc_rdy_d;
      s1_val_q    <= accept;
      s1_load_q   <= load;
      s1_emit_q   <= emit;
      s1_last_q   <= acc_last;
      s2_emit_q   <= s1_val_q && s1_emit_q;
      s2_last_q   <= s1_last_q;
    end
  end

  for (genvar c = 0; c < DEPTH_NB; c++) begin : g_ch
    logic signed [ACC_WIDTH-1:0] acc_c, bias_c, b_q, pool_q, pool_d, relu_v;
    logic signed [ACC_WIDTH:0]   rnd, shifted;
    logic [IMG_WIDTH-1:0]        res_c;

    assign acc_c  = acc_bus[c*ACC_WIDTH +: ACC_WIDTH];
    assign bias_c = bias_bus[c*ACC_WIDTH +: ACC_WIDTH];

    always_comb begin
      pool_d = pool_q;
      if (s1_val_q) begin
        if (s1_load_q)  pool_d = b_q;
        else if (avg_q) pool_d = sat_acc({pool_q[ACC_WIDTH-1], pool_q} + {b_q[ACC_WIDTH-1], b_q});
        else            pool_d = (b_q > pool_q) ? b_q : pool_q;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        b_q    <= '0;
        pool_q <= '0;
      end else begin
        if (accept) b_q <= sat_acc({acc_c[ACC_WIDTH-1], acc_c} + {bias_c[ACC_WIDTH-1], bias_c});
        pool_q <= pool_d;
      end
    end

    always_comb begin
      relu_v = (relu_q && pool_q[ACC_WIDTH-1]) ? '0 : pool_q;
      rnd    = '0;
      if (round_q && shift_q != 8'd0) rnd = (ACC_WIDTH + 1)'(1) << (shift_q - 8'd1);
      shifted = ($signed({relu_v[ACC_WIDTH-1], relu_v}) + rnd) >>> shift_q;
      if (32'(shift_q) >= ACC_WIDTH) shifted = {(ACC_WIDTH + 1){relu_v[ACC_WIDTH-1]}};
      if (&shifted[ACC_WIDTH:IMG_WIDTH-1] || ~|shifted[ACC_WIDTH:IMG_WIDTH-1]) begin
        res_c = shifted[IMG_WIDTH-1:0];
      end else begin
        res_c = {shifted[ACC_WIDTH], {(IMG_WIDTH-1){~shifted[ACC_WIDTH]}}};
      end
    end

    assign res_bus[c*IMG_WIDTH +: IMG_WIDTH] = res_c;
  end

  post_process_fifo #(
    .WIDTH (ResW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (s2_emit_q),
    .wdata_i ({s2_last_q, res_bus}),
    .pop_i   (result_rdy),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pop_ok      = result_rdy && !fifo_empty;
  assign result_val  = !fifo_empty;
  assign result_bus  = result_val ? fifo_rdata[ResW-1:0] : '0;
  assign result_last = result_val && fifo_rdata[ResW];

endmodule
